// File: rtl/dbus_dm_arbiter.sv
// Two-master D-bus arbiter: core data bus (m0) and debug system-bus access (m1) share one slave.
// One outstanding transaction, round-robin on contention, optional response timeout.
module dbus_dm_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,

    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_gnt,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   tmo_q, tmo_d;

    logic            sel;
    logic            sel_req;
    logic            rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;

    // On contention the master that did not win last time goes next.
    assign sel     = (m0_req & m1_req) ? ~last_q : m1_req;
    assign sel_req = sel ? m1_req : m0_req;

    assign s_we    = sel ? m1_we    : m0_we;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_wdata = sel ? m1_wdata : m0_wdata;
    assign s_wstrb = sel ? m1_wstrb : m0_wstrb;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        s_req     = 1'b0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;

        case (state_q)
            StIdle: begin
                s_req  = sel_req;
                m0_gnt = s_gnt & sel_req & ~sel;
                m1_gnt = s_gnt & sel_req & sel;
                if (s_gnt && sel_req) begin
                    state_d = StWait;
                    owner_d = sel;
                    last_d  = sel;
                    tmo_d   = '0;
                end
            end
            StWait: begin
                if (s_rvalid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = s_rdata;
                    state_d   = StIdle;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = StIdle;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Nothing leaves the block while reset is held, whatever the state register says.
        if (rst) begin
            s_req     = 1'b0;
            m0_gnt    = 1'b0;
            m1_gnt    = 1'b0;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
        end
    end

    assign m0_rvalid = rsp_valid & ~owner_q;
    assign m1_rvalid = rsp_valid & owner_q;
    assign m0_err    = rsp_err & ~owner_q;
    assign m1_err    = rsp_err & owner_q;
    assign m0_rdata  = m0_rvalid ? rsp_data : '0;
    assign m1_rdata  = m1_rvalid ? rsp_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_dbus_dm_arbiter.sv
// Bench for dbus_dm_arbiter: directed scenarios on a TIMEOUT=8 and a TIMEOUT=0 instance
// sharing stimulus, then randomized traffic against a transaction-level model.
module tb_dbus_dm_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic        z_m0_gnt, z_m0_rvalid, z_m0_err, z_m1_gnt, z_m1_rvalid, z_m1_err;
    logic [31:0] z_m0_rdata, z_m1_rdata;
    logic        z_s_req, z_s_we;
    logic [31:0] z_s_addr, z_s_wdata;
    logic [3:0]  z_s_wstrb;

    int total = 0;
    int bad   = 0;

    dbus_dm_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    dbus_dm_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut_z (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(z_m0_gnt), .m0_rvalid(z_m0_rvalid), .m0_rdata(z_m0_rdata),
        .m0_err(z_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(z_m1_gnt), .m1_rvalid(z_m1_rvalid), .m1_rdata(z_m1_rdata),
        .m1_err(z_m1_err),
        .s_req(z_s_req), .s_we(z_s_we), .s_addr(z_s_addr), .s_wdata(z_s_wdata),
        .s_wstrb(z_s_wstrb),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        total++; if ({m0_gnt, m1_gnt, s_req} !== 3'b000) begin
            bad++; $display("FAIL rst_gnt_sreq got=%b want=000", {m0_gnt, m1_gnt, s_req}); end
        total++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin
            bad++; $display("FAIL rst_rsp got=%b want=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        total++; if ({z_m0_gnt, z_m1_gnt, z_s_req, z_m0_rvalid, z_m1_rvalid} !== 5'b0) begin
            bad++; $display("FAIL rst_z_outs got=%b want=00000",
                            {z_m0_gnt, z_m1_gnt, z_s_req, z_m0_rvalid, z_m1_rvalid}); end
        tick();
        idle_inputs();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if ({m0_gnt, m1_gnt, s_req, m0_rvalid, m1_rvalid} !== 5'b0) begin
            bad++; $display("FAIL post_rst_idle got=%b want=00000",
                            {m0_gnt, m1_gnt, s_req, m0_rvalid, m1_rvalid}); end
        tick();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0004; s_gnt = 1;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            bad++; $display("FAIL rd_gnt got=%b%b want=10", m0_gnt, m1_gnt); end
        total++; if (s_req !== 1'b1 || s_addr !== 32'h1000_0004 || s_we !== 1'b0) begin
            bad++; $display("FAIL rd_sbus req=%b addr=%h we=%b want 1 10000004 0", s_req, s_addr, s_we); end
        tick();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0) begin
            bad++; $display("FAIL rd_rsp rvalid=%b rdata=%h err=%b want 1 deadbeef 0",
                            m0_rvalid, m0_rdata, m0_err); end
        total++; if ({m1_gnt, m1_rvalid, m1_err} !== 3'b000 || m1_rdata !== 32'h0) begin
            bad++; $display("FAIL rd_m1_quiet got=%b rdata=%h want 000 0",
                            {m1_gnt, m1_rvalid, m1_err}, m1_rdata); end
        total++; if (z_m0_rvalid !== 1'b1 || z_m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_z_rsp rvalid=%b rdata=%h want 1 deadbeef", z_m0_rvalid, z_m0_rdata); end
        tick();
        s_rvalid = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr, exp_wdata;
        bit who;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h2000_0000; m0_wdata = $urandom; m0_wstrb = 4'hF;
        m1_req = 1; m1_we = 1; m1_addr = 32'h3000_0000; m1_wdata = $urandom; m1_wstrb = 4'h3;
        s_gnt = 1;
        for (int i = 0; i < 8; i++) begin
            who       = (i % 2) == 1;
            exp_addr  = who ? m1_addr : m0_addr;
            exp_wdata = who ? m1_wdata : m0_wdata;
            @(negedge clk);
            total++; if (m0_gnt !== !who || m1_gnt !== who) begin
                bad++; $display("FAIL b2b_gnt[%0d] got=%b%b want m1=%b", i, m0_gnt, m1_gnt, who); end
            total++; if (s_addr !== exp_addr || s_wdata !== exp_wdata || s_we !== 1'b1) begin
                bad++; $display("FAIL b2b_fields[%0d] addr=%h wdata=%h we=%b want %h %h 1",
                                i, s_addr, s_wdata, s_we, exp_addr, exp_wdata); end
            tick();
            if (who) begin
                m1_addr = m1_addr + 4; m1_wdata = $urandom;
                if (i >= 6) m1_req = 0;
            end else begin
                m0_addr = m0_addr + 4; m0_wdata = $urandom;
                if (i >= 6) m0_req = 0;
            end
            s_rvalid = 1; s_rdata = $urandom;
            @(negedge clk);
            total++; if (m0_rvalid !== !who || m1_rvalid !== who) begin
                bad++; $display("FAIL b2b_rsp[%0d] got=%b%b want m1=%b", i, m0_rvalid, m1_rvalid, who); end
            total++; if ({m0_gnt, m1_gnt, s_req} !== 3'b000) begin
                bad++; $display("FAIL b2b_wait_quiet[%0d] got=%b want=000", i, {m0_gnt, m1_gnt, s_req}); end
            tick();
            s_rvalid = 0;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hold_off();
        m1_req = 1; m1_we = 0; m1_addr = 32'h5000_0010; s_gnt = 1;
        @(negedge clk);
        total++; if (m1_gnt !== 1'b1) begin
            bad++; $display("FAIL hold_m1_gnt got=%b want=1", m1_gnt); end
        tick();
        m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 32'h4000_0000; m0_wdata = 32'h0BAD_CAFE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (m0_gnt !== 1'b0 || s_req !== 1'b0) begin
                bad++; $display("FAIL hold_wait[%0d] gnt=%b s_req=%b want 0 0", k, m0_gnt, s_req); end
            tick();
        end
        s_rvalid = 1; s_rdata = 32'h1111_2222;
        @(negedge clk);
        total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1111_2222 || m0_gnt !== 1'b0) begin
            bad++; $display("FAIL hold_m1_rsp rvalid=%b rdata=%h m0_gnt=%b want 1 11112222 0",
                            m1_rvalid, m1_rdata, m0_gnt); end
        tick();
        s_rvalid = 0;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1 || s_addr !== 32'h4000_0000 || s_req !== 1'b1) begin
            bad++; $display("FAIL hold_m0_gnt gnt=%b addr=%h s_req=%b want 1 40000000 1",
                            m0_gnt, s_addr, s_req); end
        tick();
        m0_req = 0; s_rvalid = 1;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b1) begin
            bad++; $display("FAIL hold_m0_rsp got=%b want=1", m0_rvalid); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        m0_req = 1; m0_we = 0; m0_addr = 32'h6000_0000; s_gnt = 1;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1) begin
            bad++; $display("FAIL tmo_gnt got=%b want=1", m0_gnt); end
        tick();
        m0_req = 0; s_gnt = 0; s_rdata = 32'hAAAA_5555;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                total++; if (m0_rvalid !== 1'b0) begin
                    bad++; $display("FAIL tmo_early[%0d] rvalid=%b want=0", k, m0_rvalid); end
            end else begin
                total++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin
                    bad++; $display("FAIL tmo_err rvalid=%b err=%b rdata=%h want 1 1 0",
                                    m0_rvalid, m0_err, m0_rdata); end
            end
            tick();
        end
        s_rvalid = 1; s_rdata = 32'hBAD0_0001;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++; $display("FAIL tmo_stray got=%b%b want=00", m0_rvalid, m1_rvalid); end
        total++; if (z_m0_rvalid !== 1'b1 || z_m0_err !== 1'b0 || z_m0_rdata !== 32'hBAD0_0001) begin
            bad++; $display("FAIL tmo_z_rsp rvalid=%b err=%b rdata=%h want 1 0 bad00001",
                            z_m0_rvalid, z_m0_err, z_m0_rdata); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        m1_req = 1; m1_addr = 32'h7000_0000; s_gnt = 1;
        @(negedge clk);
        total++; if (m1_gnt !== 1'b1) begin
            bad++; $display("FAIL rmw_gnt got=%b want=1", m1_gnt); end
        tick();
        rst = 1; m0_req = 1; m0_addr = 32'h7100_0000; s_rvalid = 1; s_rdata = 32'h5555_5555;
        @(negedge clk);
        total++; if ({m0_gnt, m1_gnt, s_req, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 7'b0) begin
            bad++; $display("FAIL rmw_in_rst got=%b want=0000000",
                            {m0_gnt, m1_gnt, s_req, m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        total++; if ({z_m0_gnt, z_m1_gnt, z_s_req, z_m0_rvalid, z_m1_rvalid} !== 5'b0) begin
            bad++; $display("FAIL rmw_z_in_rst got=%b want=00000",
                            {z_m0_gnt, z_m1_gnt, z_s_req, z_m0_rvalid, z_m1_rvalid}); end
        tick();
        rst = 0; s_rvalid = 0;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++; $display("FAIL rmw_first m0_gnt=%b m1_gnt=%b m1_rvalid=%b want 1 0 0",
                            m0_gnt, m1_gnt, m1_rvalid); end
        tick();
        m0_req = 0; s_rvalid = 1; s_rdata = 32'h0000_600D;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_600D || m1_rvalid !== 1'b0) begin
            bad++; $display("FAIL rmw_rsp m0_rvalid=%b rdata=%h m1_rvalid=%b want 1 0000600d 0",
                            m0_rvalid, m0_rdata, m1_rvalid); end
        tick();
        s_rvalid = 0;
        @(negedge clk);
        total++; if (m1_gnt !== 1'b1) begin
            bad++; $display("FAIL rmw_m1_next got=%b want=1", m1_gnt); end
        tick();
        m1_req = 0; s_rvalid = 1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_no_timeout();
        int early = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h8000_0000; s_gnt = 1;
        @(negedge clk);
        total++; if (z_m1_gnt !== 1'b1 || m1_gnt !== 1'b1) begin
            bad++; $display("FAIL nto_gnt got=%b%b want=11", z_m1_gnt, m1_gnt); end
        tick();
        m1_req = 0; s_gnt = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 300) begin
                s_rvalid = 1; s_rdata = 32'h1234_5678;
            end
            @(negedge clk);
            if (k < 300 && (z_m1_rvalid !== 1'b0 || z_m1_err !== 1'b0)) early++;
            if (k == 8) begin
                total++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1) begin
                    bad++; $display("FAIL nto_t8_err rvalid=%b err=%b want 1 1", m1_rvalid, m1_err); end
            end
            if (k == 300) begin
                total++; if (z_m1_rvalid !== 1'b1 || z_m1_err !== 1'b0 || z_m1_rdata !== 32'h1234_5678)
                begin
                    bad++; $display("FAIL nto_rsp rvalid=%b err=%b rdata=%h want 1 0 12345678",
                                    z_m1_rvalid, z_m1_err, z_m1_rdata); end
                total++; if (m1_rvalid !== 1'b0) begin
                    bad++; $display("FAIL nto_t8_late rvalid=%b want=0", m1_rvalid); end
            end
            tick();
        end
        total++; if (early !== 0) begin
            bad++; $display("FAIL nto_early count=%0d want=0", early); end
        idle_inputs();
        tick();
    endtask

    // Randomized traffic on the TIMEOUT=8 instance. The slave answers 1..8 cycles after grant,
    // or drops the request so that the timeout must fire.
    task automatic test_random();
        bit          busy, owner, last, cand, any;
        bit          eg0, eg1, ev0, ev1, ee0, ee1;
        int          gcyc, resp_at, lat;
        bit          rq[2], wq[2];
        logic [31:0] aq[2], dq[2];
        logic [3:0]  sq[2];
        logic [31:0] rd, ed0, ed1;
        do_reset();
        busy = 0; owner = 0; last = 1; gcyc = 0; resp_at = -1;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 0; wq[m] = 0; aq[m] = '0; dq[m] = '0; sq[m] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] && $urandom_range(0, 2) == 0) begin
                    rq[m] = 1; wq[m] = 1'($urandom_range(0, 1));
                    aq[m] = $urandom; dq[m] = $urandom; sq[m] = 4'($urandom);
                end
            end
            m0_req = rq[0]; m0_we = wq[0]; m0_addr = aq[0]; m0_wdata = dq[0]; m0_wstrb = sq[0];
            m1_req = rq[1]; m1_we = wq[1]; m1_addr = aq[1]; m1_wdata = dq[1]; m1_wstrb = sq[1];
            s_gnt    = $urandom_range(0, 3) != 0;
            rd       = $urandom;
            s_rvalid = (resp_at == cyc);
            s_rdata  = rd;

            any  = rq[0] | rq[1];
            cand = (rq[0] && rq[1]) ? !last : rq[1];
            {eg0, eg1, ev0, ev1, ee0, ee1} = '0;
            ed0 = '0; ed1 = '0;
            if (!busy) begin
                eg0 = any && s_gnt && !cand;
                eg1 = any && s_gnt && cand;
            end else if (s_rvalid) begin
                if (owner) begin ev1 = 1; ed1 = rd; end else begin ev0 = 1; ed0 = rd; end
            end else if (cyc - gcyc == 8) begin
                if (owner) begin ev1 = 1; ee1 = 1; end else begin ev0 = 1; ee0 = 1; end
            end

            @(negedge clk);
            total++; if (m0_gnt !== eg0 || m1_gnt !== eg1 || s_req !== (!busy && any)) begin
                bad++; $display("FAIL rnd_gnt[%0d] gnt=%b%b s_req=%b want %b%b %b",
                                cyc, m0_gnt, m1_gnt, s_req, eg0, eg1, !busy && any); end
            if (!busy && any) begin
                total++; if (s_addr !== aq[cand] || s_wdata !== dq[cand] || s_we !== wq[cand] ||
                             s_wstrb !== sq[cand]) begin
                    bad++; $display("FAIL rnd_mux[%0d] addr=%h wdata=%h we=%b strb=%h want %h %h %b %h",
                                    cyc, s_addr, s_wdata, s_we, s_wstrb,
                                    aq[cand], dq[cand], wq[cand], sq[cand]); end
            end
            total++; if (m0_rvalid !== ev0 || m1_rvalid !== ev1 || m0_err !== ee0 || m1_err !== ee1)
            begin
                bad++; $display("FAIL rnd_rsp[%0d] rv=%b%b err=%b%b want %b%b %b%b",
                                cyc, m0_rvalid, m1_rvalid, m0_err, m1_err, ev0, ev1, ee0, ee1); end
            total++; if (m0_rdata !== ed0 || m1_rdata !== ed1) begin
                bad++; $display("FAIL rnd_rdata[%0d] got=%h %h want %h %h",
                                cyc, m0_rdata, m1_rdata, ed0, ed1); end

            if (eg0 || eg1) begin
                busy = 1; owner = cand; last = cand; gcyc = cyc; rq[cand] = 0;
                lat = $urandom_range(1, 11);
                resp_at = (lat <= 8) ? cyc + lat : -1;
            end else if (ev0 || ev1) begin
                busy = 0; resp_at = -1;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hold_off();
        test_timeout();
        test_reset_mid_wait();
        test_no_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbus_dm_arbiter.md
# dbus_dm_arbiter

Two-master arbiter sharing one D-bus slave port between the riscv32 core-0 data bus (master 0) and the debug module's system-bus-access port (master 1). Sits between those masters and the D-bus interconnect, so the debugger can read and write memory and GPIO while the core runs. It allows one outstanding transaction at a time, with round-robin fairness and a response timeout that returns an error instead of hanging a master.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, cycles to wait for slave response before error; 0 disables timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  master request valid
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_wstrb, m1_wstrb  in  DW/8  byte enables
- m0_gnt, m1_gnt  out  1  request accepted this cycle
- m0_rvalid, m1_rvalid  out  1  response (read data or write ack) valid, 1-cycle pulse
- m0_rdata, m1_rdata  out  DW  read data, valid with rvalid
- m0_err, m1_err  out  1  response is a timeout error, valid with rvalid
- s_req  out  1  request to slave
- s_we, s_addr, s_wdata, s_wstrb  out  —  muxed request fields
- s_gnt  in  1  slave accepted request
- s_rvalid  in  1  slave response (reads and writes both respond)
- s_rdata  in  DW  slave read data

## Operation

- FSM states: IDLE, WAIT. Registers: owner (1 bit), last (1 bit, last granted master), tmo_cnt (8 bits, sized to hold TIMEOUT).
- IDLE:
  - sel = requesting master. If both request, sel = !last; if only one requests, sel = that master.
  - s_req = m_sel_req; s_we/addr/wdata/wstrb = sel fields (combinational mux). With no request, s_req = 0 and the fields are don't-care.
  - m_sel_gnt = s_gnt & m_sel_req. Non-selected gnt = 0.
  - On s_gnt & s_req: owner <= sel, last <= sel, tmo_cnt <= 0, go to WAIT.
- WAIT:
  - s_req = 0; both gnt = 0. New requests are held off and must stay asserted (bus rule: master holds req and fields until gnt).
  - s_rvalid: m_owner_rvalid = 1, m_owner_rdata = s_rdata, m_owner_err = 0; go to IDLE.
  - Otherwise, if TIMEOUT != 0 and tmo_cnt == TIMEOUT-1: m_owner_rvalid = 1, rdata = 0, err = 1; go to IDLE. Otherwise tmo_cnt++.
  - A late s_rvalid that arrives after a timeout, while in IDLE, is ignored.
- Non-owner rvalid/err are always 0. rdata is s_rdata when rvalid is high, else 0.
- s_rvalid in the same cycle as s_gnt (zero-latency slave) is not supported; the slave responds at least 1 cycle after gnt.

## Timing

- Reset (rst high at a clk edge): state = IDLE, last = 1 (master 0 wins the first contention), owner = 0, tmo_cnt = 0.
  - While rst is high, all gnt, rvalid, err and s_req are forced to 0.
  - Reset mid-WAIT abandons the transaction with no response to the master.
- Grant is combinational in IDLE: request at cycle N with s_gnt high at N gives m_gnt at N and state WAIT at N+1.
- Response passes through combinationally: s_rvalid at cycle K gives m_rvalid at K and IDLE at K+1, so a new grant is possible at K+1.
- Minimum throughput: 1 transaction per 2 cycles per slave-response latency of 1.
- Timeout: with TIMEOUT = T and grant at cycle N, the error response is at cycle N+T.
- Fairness: with both masters requesting continuously, grants alternate 0, 1, 0, 1, and so on.

## Test plan

- Single read from m0 only: m0_req, addr 0x1000_0004, slave gnt at once and rvalid 1 cycle later with 0xDEADBEEF. Require m0_gnt at N, m0_rvalid = 1 with rdata 0xDEADBEEF at N+1, m0_err = 0, m1 outputs all 0.
- Simultaneous m0/m1 writes right after reset, slave 1-cycle response: m0 is granted first, m1 is granted in the cycle after m0_rvalid, and s_addr/s_wdata match each master in turn. Four back-to-back pairs show alternating grants.
- m1 read while m0 raises req during WAIT: m0_gnt stays 0 until m1_rvalid, then m0 is granted the next cycle; s_req stays 0 during WAIT.
- Timeout with TIMEOUT = 8, slave never responds: m0_rvalid = 1, m0_err = 1, rdata = 0 exactly 8 cycles after gnt. A subsequent stray s_rvalid in IDLE produces no m0/m1 rvalid.
- rst asserted mid-WAIT: all outputs are 0 during reset. After release, both masters requesting gives m0 granted first and no stale response delivered.
- TIMEOUT = 0 with slave response after 300 cycles: no error; m1_rvalid = 1 with slave data at cycle 300.
